// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM device model: command encodings, geometry,
// error-flag bit positions and mode/burst helper functions.
package sdram_pkg;

    localparam int ADDR_WIDTH = 13;
    localparam int BA_WIDTH   = 2;
    localparam int NUM_BANKS  = 4;
    localparam int COL_WIDTH  = 9;
    localparam int DATA_WIDTH = 16;
    localparam int PIPE_DEPTH = 3 + 8;
    localparam int ERR_WIDTH  = 8;

    // {ras_n, cas_n, we_n}
    typedef enum logic [2:0] {
        CMD_MODE_SET   = 3'b000,
        CMD_REFRESH    = 3'b001,
        CMD_PRECHARGE  = 3'b010,
        CMD_ACTIVATE   = 3'b011,
        CMD_WRITE      = 3'b100,
        CMD_READ       = 3'b101,
        CMD_BURST_TERM = 3'b110,
        CMD_NOP        = 3'b111
    } sdram_cmd_e;

    // Refresh-while-open and late-refresh share bit 7 to keep err at 8 bits.
    localparam int ERR_NO_MODE  = 0;
    localparam int ERR_MODE     = 1;
    localparam int ERR_ACT_OPEN = 2;
    localparam int ERR_NOT_OPEN = 3;
    localparam int ERR_RCD      = 4;
    localparam int ERR_RP       = 5;
    localparam int ERR_RAS      = 6;
    localparam int ERR_REF_OPEN = 7;
    localparam int ERR_REF_LATE = 7;

    typedef struct packed {
        logic       legal;
        logic [1:0] bl_log2;
        logic [1:0] cl;
    } mode_t;

    function automatic mode_t decode_mode(input logic [2:0] bl_field, input logic [2:0] cl_field);
        mode_t m;
        m.legal   = (bl_field <= 3'd3) && ((cl_field == 3'd2) || (cl_field == 3'd3));
        m.bl_log2 = bl_field[1:0];
        m.cl      = cl_field[1:0];
        return m;
    endfunction

    // Sequential burst: only the low log2(BL) column bits wrap.
    function automatic logic [COL_WIDTH-1:0] burst_col(input logic [COL_WIDTH-1:0] col,
                                                       input logic [2:0] beat,
                                                       input logic [1:0] bl_log2);
        logic [COL_WIDTH-1:0] low_mask;
        logic [COL_WIDTH-1:0] stepped;
        low_mask = ~({COL_WIDTH{1'b1}} << bl_log2);
        stepped  = col + COL_WIDTH'(beat);
        return (col & ~low_mask) | (stepped & low_mask);
    endfunction

endpackage

// File: rtl/sdram_dev_if.sv
// Device-side SDRAM bus between sdram_core (host) and the device model (sub).
interface sdram_dev_if;
    import sdram_pkg::*;

    logic [2:0]            cmd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [BA_WIDTH-1:0]   ba;
    logic                  cs;
    logic                  cke;
    logic [1:0]            dqm;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] read_data;

    modport sub  (input cmd, addr, ba, cs, cke, dqm, wr_en, write_data, output read_data);
    modport host (output cmd, addr, ba, cs, cke, dqm, wr_en, write_data, input read_data);

endinterface

// File: rtl/sdram_model_bank.sv
// One bank of the device model: open/row state, activate/close timers,
// auto-precharge countdown and the per-bank timing checks.
module sdram_model_bank
    import sdram_pkg::*;
#(
    parameter int DELAY_RCD = 1,
    parameter int DELAY_RP  = 1,
    parameter int DELAY_RC  = 3,
    parameter int DELAY_RAS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  act,
    input  logic                  pre,
    input  logic                  access,
    input  logic                  ap_req,
    input  logic [4:0]            ap_delay,
    input  logic [ADDR_WIDTH-1:0] row_in,
    output logic                  is_open,
    output logic [ADDR_WIDTH-1:0] row,
    output logic                  err_act_open,
    output logic                  err_rcd,
    output logic                  err_rp,
    output logic                  err_ras
);

    localparam logic [7:0] T_RCD = 8'(DELAY_RCD);
    localparam logic [7:0] T_RP  = 8'(DELAY_RP);
    localparam logic [7:0] T_RC  = 8'(DELAY_RC);
    localparam logic [7:0] T_RAS = 8'(DELAY_RAS);

    logic [7:0] act_cnt;
    logic [7:0] close_cnt;
    logic       ap_pending;
    logic [4:0] ap_cnt;

    assign err_act_open = act && is_open;
    assign err_rp       = act && ((close_cnt < T_RP) || (act_cnt < T_RC));
    assign err_ras      = pre && is_open && (act_cnt < T_RAS);
    assign err_rcd      = access && (act_cnt < T_RCD);

    // Later assignments take priority: explicit commands override a pending auto-close.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_open    <= 1'b0;
            row        <= '0;
            act_cnt    <= '1;
            close_cnt  <= '1;
            ap_pending <= 1'b0;
            ap_cnt     <= '0;
        end else begin
            if (act_cnt != '1) act_cnt <= act_cnt + 8'd1;
            if (close_cnt != '1) close_cnt <= close_cnt + 8'd1;
            if (ap_pending) begin
                ap_cnt <= ap_cnt - 5'd1;
                if (ap_cnt == 5'd1) begin
                    is_open    <= 1'b0;
                    close_cnt  <= '0;
                    ap_pending <= 1'b0;
                end
            end
            if (access) begin
                if (ap_req && (ap_delay == 5'd0)) begin
                    is_open    <= 1'b0;
                    close_cnt  <= '0;
                    ap_pending <= 1'b0;
                end else begin
                    ap_pending <= ap_req;
                    ap_cnt     <= ap_delay;
                end
            end
            if (pre) begin
                is_open    <= 1'b0;
                close_cnt  <= '0;
                ap_pending <= 1'b0;
            end
            if (act) begin
                is_open    <= 1'b1;
                row        <= row_in;
                act_cnt    <= '0;
                ap_pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sdram_dev_model.sv
// SDRAM device responder: command decode, mode register, refresh tracking,
// write bursts, CAS-latency read pipeline and a small backing store.
module sdram_dev_model
    import sdram_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH   = 12,
    parameter int DELAY_RCD        = 1,
    parameter int DELAY_RP         = 1,
    parameter int DELAY_RC         = 3,
    parameter int DELAY_RAS        = 3,
    parameter int REF_INTERVAL_MAX = 400
) (
    input  logic                 clk,
    input  logic                 rst,
    sdram_dev_if.sub             dev_if,
    output logic [ERR_WIDTH-1:0] err,
    output logic                 mode_valid,
    output logic [15:0]          ref_count
);

    localparam int MEM_DEPTH = 1 << MEM_ADDR_WIDTH;
    typedef logic [MEM_ADDR_WIDTH-1:0] mem_idx_t;

    function automatic mem_idx_t store_index(input logic [BA_WIDTH-1:0] b,
                                             input logic [ADDR_WIDTH-1:0] r,
                                             input logic [COL_WIDTH-1:0] c);
        return mem_idx_t'({b, r, c});
    endfunction

    sdram_cmd_e            cmd;
    mode_t                 mode_dec;
    logic                  do_act, do_read, do_write, do_pre, do_ref, do_mode;
    logic                  no_mode, not_open, start_read, start_write, auto_pre;
    logic                  sel_open;
    logic [ADDR_WIDTH-1:0] sel_row;
    logic [COL_WIDTH-1:0]  col;
    logic [1:0]            bl_log2_q;
    logic [1:0]            cl_q;
    logic [2:0]            bl_last;
    logic [4:0]            ap_delay;

    logic [NUM_BANKS-1:0]  bank_open;
    logic [ADDR_WIDTH-1:0] bank_row [NUM_BANKS];
    logic [NUM_BANKS-1:0]  b_act_open, b_rcd, b_rp, b_ras;

    logic [15:0]           ref_timer;
    logic                  ref_seen, ref_late;
    logic [ERR_WIDTH-1:0]  err_set;

    logic                  wr_active;
    logic [BA_WIDTH-1:0]   wr_ba;
    logic [ADDR_WIDTH-1:0] wr_row;
    logic [COL_WIDTH-1:0]  wr_col;
    logic [2:0]            wr_beat;
    logic                  wr_now;
    mem_idx_t              wr_addr;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [PIPE_DEPTH-1:0] pipe_valid, rd_valid_new;
    mem_idx_t              pipe_idx [PIPE_DEPTH];
    mem_idx_t              rd_idx_new [PIPE_DEPTH];
    logic [DATA_WIDTH-1:0] read_data_q;

    assign dev_if.read_data = read_data_q;

    // Deselected or clock-disabled cycles decode as NOP.
    always_comb begin
        cmd = CMD_NOP;
        if (dev_if.cke && !dev_if.cs) cmd = sdram_cmd_e'(dev_if.cmd);
    end

    assign no_mode     = !mode_valid && ((cmd == CMD_ACTIVATE) || (cmd == CMD_READ) ||
                                         (cmd == CMD_WRITE) || (cmd == CMD_BURST_TERM));
    assign do_act      = (cmd == CMD_ACTIVATE) && mode_valid;
    assign do_read     = (cmd == CMD_READ) && mode_valid;
    assign do_write    = (cmd == CMD_WRITE) && mode_valid;
    assign do_pre      = (cmd == CMD_PRECHARGE);
    assign do_ref      = (cmd == CMD_REFRESH);
    assign do_mode     = (cmd == CMD_MODE_SET);
    assign auto_pre    = dev_if.addr[10];
    assign col         = dev_if.addr[COL_WIDTH-1:0];
    assign sel_open    = bank_open[dev_if.ba];
    assign sel_row     = bank_row[dev_if.ba];
    assign start_read  = do_read && sel_open;
    assign start_write = do_write && sel_open;
    assign not_open    = (do_read || do_write) && !sel_open;
    assign mode_dec    = decode_mode(dev_if.addr[2:0], dev_if.addr[6:4]);

    always_comb begin
        bl_last = 3'd0;
        case (bl_log2_q)
            2'd1:    bl_last = 3'd1;
            2'd2:    bl_last = 3'd3;
            2'd3:    bl_last = 3'd7;
            default: bl_last = 3'd0;
        endcase
    end

    // Auto-precharge closes the bank at the cycle carrying the last beat.
    assign ap_delay = start_read ? ({3'b000, cl_q} + {2'b00, bl_last}) : {2'b00, bl_last};

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic hit;
        assign hit = (dev_if.ba == BA_WIDTH'(b));
        sdram_model_bank #(
            .DELAY_RCD(DELAY_RCD),
            .DELAY_RP (DELAY_RP),
            .DELAY_RC (DELAY_RC),
            .DELAY_RAS(DELAY_RAS)
        ) u_bank (
            .clk         (clk),
            .rst         (rst),
            .act         (do_act && hit),
            .pre         (do_pre && (auto_pre || hit)),
            .access      ((start_read || start_write) && hit),
            .ap_req      (auto_pre),
            .ap_delay    (ap_delay),
            .row_in      (dev_if.addr),
            .is_open     (bank_open[b]),
            .row         (bank_row[b]),
            .err_act_open(b_act_open[b]),
            .err_rcd     (b_rcd[b]),
            .err_rp      (b_rp[b]),
            .err_ras     (b_ras[b])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_valid <= 1'b0;
            bl_log2_q  <= 2'd0;
            cl_q       <= 2'd2;
        end else if (do_mode && mode_dec.legal) begin
            mode_valid <= 1'b1;
            bl_log2_q  <= mode_dec.bl_log2;
            cl_q       <= mode_dec.cl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_count <= '0;
            ref_timer <= '1;
            ref_seen  <= 1'b0;
        end else if (do_ref) begin
            ref_count <= ref_count + 16'd1;
            ref_timer <= '0;
            ref_seen  <= 1'b1;
        end else if (ref_timer != '1) begin
            ref_timer <= ref_timer + 16'd1;
        end
    end

    assign ref_late = ref_seen && (ref_timer > 16'(REF_INTERVAL_MAX));

    always_comb begin
        err_set               = '0;
        err_set[ERR_NO_MODE]  = no_mode;
        err_set[ERR_MODE]     = do_mode && !mode_dec.legal;
        err_set[ERR_ACT_OPEN] = |b_act_open;
        err_set[ERR_NOT_OPEN] = not_open;
        err_set[ERR_RCD]      = |b_rcd;
        err_set[ERR_RP]       = |b_rp;
        err_set[ERR_RAS]      = |b_ras;
        err_set[ERR_REF_OPEN] = do_ref && (|bank_open);
        err_set[ERR_REF_LATE] = err_set[ERR_REF_LATE] | ref_late;
    end

    always_ff @(posedge clk) begin
        if (rst) err <= '0;
        else     err <= err | err_set;
    end

    // A new READ or WRITE truncates any write burst still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_active <= 1'b0;
            wr_ba     <= '0;
            wr_row    <= '0;
            wr_col    <= '0;
            wr_beat   <= '0;
        end else if (start_write) begin
            wr_active <= (bl_last != 3'd0);
            wr_ba     <= dev_if.ba;
            wr_row    <= sel_row;
            wr_col    <= col;
            wr_beat   <= 3'd1;
        end else if (start_read) begin
            wr_active <= 1'b0;
        end else if (wr_active) begin
            wr_beat <= wr_beat + 3'd1;
            if (wr_beat == bl_last) wr_active <= 1'b0;
        end
    end

    always_comb begin
        wr_now  = 1'b0;
        wr_addr = '0;
        if (start_write) begin
            wr_now  = dev_if.wr_en;
            wr_addr = store_index(dev_if.ba, sel_row, col);
        end else if (wr_active && !start_read) begin
            wr_now  = dev_if.wr_en;
            wr_addr = store_index(wr_ba, wr_row, burst_col(wr_col, wr_beat, bl_log2_q));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_now) begin
            if (!dev_if.dqm[0]) mem[wr_addr][7:0]  <= dev_if.write_data[7:0];
            if (!dev_if.dqm[1]) mem[wr_addr][15:8] <= dev_if.write_data[15:8];
        end
    end

    // Slot j feeds read_data for the cycle j+2 after the READ, so beat k lands in slot CL-2+k.
    always_comb begin
        int beat;
        beat = 0;
        for (int j = 0; j < PIPE_DEPTH; j++) begin
            beat            = j + 2 - int'(cl_q);
            rd_valid_new[j] = (beat >= 0) && (beat <= int'(bl_last));
            rd_idx_new[j]   = store_index(dev_if.ba, sel_row, burst_col(col, beat[2:0], bl_log2_q));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            read_data_q <= '0;
            pipe_valid  <= '0;
            for (int j = 0; j < PIPE_DEPTH; j++) pipe_idx[j] <= '0;
        end else begin
            read_data_q <= pipe_valid[0] ? mem[pipe_idx[0]] : '0;
            if (start_read) begin
                pipe_valid <= rd_valid_new;
                pipe_idx   <= rd_idx_new;
            end else begin
                pipe_valid <= pipe_valid >> 1;
                for (int j = 0; j < PIPE_DEPTH - 1; j++) pipe_idx[j] <= pipe_idx[j + 1];
                pipe_idx[PIPE_DEPTH-1] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sdram_dev_model.sv
// Directed self-checking bench for sdram_dev_model: data path, CAS latency,
// burst wrap, byte masking, sticky timing flags and reset behaviour.
module tb_sdram_dev_model;
    import sdram_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  err;
    logic        mode_valid;
    logic [15:0] ref_count;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    sdram_dev_if dev_if ();

    sdram_dev_model #(
        .MEM_ADDR_WIDTH  (12),
        .DELAY_RCD       (1),
        .DELAY_RP        (1),
        .DELAY_RC        (3),
        .DELAY_RAS       (3),
        .REF_INTERVAL_MAX(400)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dev_if    (dev_if),
        .err       (err),
        .mode_valid(mode_valid),
        .ref_count (ref_count)
    );

    // Drive one bus cycle, then land 1 time unit after the sampling edge.
    task automatic applyStimulus(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a,
                                 input logic we, input logic [15:0] wd, input logic [1:0] m);
        dev_if.cmd        = c;
        dev_if.ba         = b;
        dev_if.addr       = a;
        dev_if.cs         = 1'b0;
        dev_if.cke        = 1'b1;
        dev_if.wr_en      = we;
        dev_if.write_data = wd;
        dev_if.dqm        = m;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a);
        applyStimulus(c, b, a, 1'b0, 16'h0000, 2'b00);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(CMD_NOP, 2'd0, 13'h000);
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        rst               = 1'b1;
        dev_if.cmd        = CMD_NOP;
        dev_if.ba         = 2'd0;
        dev_if.addr       = 13'h000;
        dev_if.cs         = 1'b1;
        dev_if.cke        = 1'b1;
        dev_if.wr_en      = 1'b0;
        dev_if.write_data = 16'h0000;
        dev_if.dqm        = 2'b00;
        idle(2);
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_err",       {8'h00, err},         16'h0000);
        checkOutput("rst_mode",      {15'd0, mode_valid},  16'h0000);
        checkOutput("rst_refcnt",    ref_count,            16'h0000);
        checkOutput("rst_read_data", dev_if.read_data,     16'h0000);

        $display("[TB] BL1 CL2 write/read with auto-precharge");
        issue(CMD_PRECHARGE, 2'd0, 13'h400);
        idle(1);
        issue(CMD_MODE_SET, 2'd0, 13'h020);
        checkOutput("mode_valid_set", {15'd0, mode_valid}, 16'h0001);
        issue(CMD_REFRESH, 2'd0, 13'h000);
        checkOutput("ref_count_1", ref_count, 16'h0001);
        idle(3);
        issue(CMD_ACTIVATE, 2'd1, 13'h005);
        idle(1);
        applyStimulus(CMD_WRITE, 2'd1, 13'h004, 1'b1, 16'hBEEF, 2'b00);
        issue(CMD_READ, 2'd1, 13'h404);
        checkOutput("t1_cyc1", dev_if.read_data, 16'h0000);
        idle(1);
        checkOutput("t1_cyc2", dev_if.read_data, 16'hBEEF);
        idle(1);
        checkOutput("t1_cyc3", dev_if.read_data, 16'h0000);
        checkOutput("t1_err", {8'h00, err}, 16'h0000);

        $display("[TB] BL2 CL3 wrapped burst");
        issue(CMD_MODE_SET, 2'd0, 13'h031);
        idle(1);
        issue(CMD_ACTIVATE, 2'd1, 13'h005);
        idle(1);
        applyStimulus(CMD_WRITE, 2'd1, 13'h007, 1'b1, 16'h1111, 2'b00);
        applyStimulus(CMD_NOP, 2'd0, 13'h000, 1'b1, 16'h2222, 2'b00);
        issue(CMD_READ, 2'd1, 13'h006);
        checkOutput("t2_cyc1", dev_if.read_data, 16'h0000);
        idle(1);
        checkOutput("t2_cyc2", dev_if.read_data, 16'h0000);
        idle(1);
        checkOutput("t2_beat0", dev_if.read_data, 16'h2222);
        idle(1);
        checkOutput("t2_beat1", dev_if.read_data, 16'h1111);
        idle(1);
        checkOutput("t2_after", dev_if.read_data, 16'h0000);

        $display("[TB] byte mask");
        issue(CMD_MODE_SET, 2'd0, 13'h020);
        idle(1);
        applyStimulus(CMD_WRITE, 2'd1, 13'h00A, 1'b1, 16'h1234, 2'b00);
        idle(1);
        applyStimulus(CMD_WRITE, 2'd1, 13'h00A, 1'b1, 16'hAABB, 2'b10);
        issue(CMD_READ, 2'd1, 13'h00A);
        idle(1);
        checkOutput("t3_masked", dev_if.read_data, 16'h12BB);
        checkOutput("t3_err", {8'h00, err}, 16'h0000);

        $display("[TB] tRCD violation and closed-bank access");
        issue(CMD_ACTIVATE, 2'd2, 13'h003);
        issue(CMD_READ, 2'd2, 13'h000);
        checkOutput("t4_rcd", {8'h00, err}, 16'h0010);
        idle(30);
        checkOutput("t4_rcd_sticky", {8'h00, err}, 16'h0010);
        issue(CMD_READ, 2'd3, 13'h000);
        checkOutput("t4_not_open", {8'h00, err}, 16'h0018);
        pulseReset();
        checkOutput("t4_rst_err", {8'h00, err}, 16'h0000);

        $display("[TB] mode errors");
        issue(CMD_ACTIVATE, 2'd0, 13'h001);
        checkOutput("t5_no_mode", {8'h00, err}, 16'h0001);
        pulseReset();
        issue(CMD_MODE_SET, 2'd0, 13'h007);
        checkOutput("t5_bad_mode", {8'h00, err}, 16'h0002);
        checkOutput("t5_bad_mode_valid", {15'd0, mode_valid}, 16'h0000);
        pulseReset();

        $display("[TB] tRAS, tRP and refresh with open bank");
        issue(CMD_MODE_SET, 2'd0, 13'h020);
        idle(1);
        issue(CMD_ACTIVATE, 2'd0, 13'h005);
        issue(CMD_PRECHARGE, 2'd0, 13'h000);
        checkOutput("t5_ras", {8'h00, err}, 16'h0040);
        issue(CMD_ACTIVATE, 2'd0, 13'h005);
        checkOutput("t5_rp", {8'h00, err}, 16'h0060);
        idle(2);
        issue(CMD_REFRESH, 2'd0, 13'h000);
        checkOutput("t5_ref_open", {8'h00, err}, 16'h00E0);
        checkOutput("t5_ref_count", ref_count, 16'h0001);
        pulseReset();

        $display("[TB] refresh interval");
        issue(CMD_REFRESH, 2'd0, 13'h000);
        idle(401);
        checkOutput("t5_ref_edge", {8'h00, err}, 16'h0000);
        idle(1);
        checkOutput("t5_ref_late", {8'h00, err}, 16'h0080);
        pulseReset();

        $display("[TB] reset during burst");
        issue(CMD_REFRESH, 2'd0, 13'h000);
        issue(CMD_MODE_SET, 2'd0, 13'h021);
        idle(1);
        issue(CMD_ACTIVATE, 2'd0, 13'h001);
        idle(1);
        applyStimulus(CMD_WRITE, 2'd0, 13'h000, 1'b1, 16'h5555, 2'b00);
        applyStimulus(CMD_NOP, 2'd0, 13'h000, 1'b1, 16'h6666, 2'b00);
        issue(CMD_READ, 2'd0, 13'h000);
        checkOutput("t6_mode_pre", {15'd0, mode_valid}, 16'h0001);
        checkOutput("t6_ref_pre", ref_count, 16'h0001);
        idle(1);
        checkOutput("t6_beat0", dev_if.read_data, 16'h5555);
        idle(1);
        checkOutput("t6_beat1", dev_if.read_data, 16'h6666);
        pulseReset();
        checkOutput("t6_rd_after_rst", dev_if.read_data, 16'h0000);
        checkOutput("t6_mode_after_rst", {15'd0, mode_valid}, 16'h0000);
        checkOutput("t6_ref_after_rst", ref_count, 16'h0000);
        idle(1);
        checkOutput("t6_rd_quiet", dev_if.read_data, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
